// File: rtl/shift_reg_pkg.sv
// Shared constants and types for the shift_reg delay line.
package shift_reg_pkg;

  localparam int unsigned SHIFT_REG_DEPTH_DEFAULT = 4;
  localparam int unsigned SHIFT_REG_WIDTH_DEFAULT = 1;
  localparam int unsigned SHIFT_REG_DEPTH_MAX     = 64;

  typedef logic [SHIFT_REG_WIDTH_DEFAULT-1:0] shift_word_t;

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit register of the delay line with synchronous active-high reset.
module shift_stage
  import shift_reg_pkg::*;
#(
  parameter int unsigned           WIDTH     = SHIFT_REG_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/shift_reg.sv
// Serial-in/serial-out delay line of DEPTH chained stages; q is the last stage.
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int unsigned      DEPTH     = SHIFT_REG_DEPTH_DEFAULT,
  parameter int unsigned      WIDTH     = SHIFT_REG_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject illegal shapes at elaboration.
  if (DEPTH < 1 || DEPTH > SHIFT_REG_DEPTH_MAX) begin : g_bad_depth
    $error("shift_reg: DEPTH must be in 1..64");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("shift_reg: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] stage [DEPTH];

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    if (i == 0) begin : g_head
      assign stage_d = d;
    end else begin : g_link
      assign stage_d = stage[i-1];
    end

    shift_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk  (clk),
      .reset(reset),
      .d    (stage_d),
      .q    (stage[i])
    );
  end

  assign q = stage[DEPTH-1];

endmodule

// File: tb/tb_shift_reg.sv
// Directed and random checks of shift_reg at DEPTH=4, DEPTH=1 and DEPTH=8/WIDTH=4.
module tb_shift_reg;
  import shift_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  shift_word_t d4, q4;
  logic        d1, q1;
  logic [3:0]  d8, q8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  shift_reg u_d4 (.clk(clk), .reset(reset), .d(d4), .q(q4));

  shift_reg #(.DEPTH(1), .WIDTH(1), .RESET_VAL(1'b0))
    u_d1 (.clk(clk), .reset(reset), .d(d1), .q(q1));

  shift_reg #(.DEPTH(8), .WIDTH(4), .RESET_VAL(4'hA))
    u_d8 (.clk(clk), .reset(reset), .d(d8), .q(q8));

  typedef struct packed {
    logic rst;
    logic d;
    logic exp_q;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp8;
    logic       model [4];
    logic       rnd_rst, rnd_d;

    // {reset, d, expected q after the edge} for the DEPTH=4 instance
    vecs = '{
      // reset held two edges with d=1
      '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0},
      // single pulse: appears after the 4th edge, gone after the 5th
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0},
      // pattern 0,1,0,1,1,0,0,1 then four flush zeros
      '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0},
      // load 1,1,1,1 then reset mid-stream
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b0},
      // fresh pulse through an all-zero chain
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0},
      // long reset with d=1
      '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0}
    };

    reset = 1'b1;
    d4    = 1'b0;
    d1    = 1'b0;
    d8    = 4'hF;
    #2;

    // Table: DEPTH=4 against hand values; DEPTH=1 follows d one edge later.
    for (int i = 0; i < NVEC; i++) begin
      reset = vecs[i].rst;
      d4    = vecs[i].d;
      d1    = vecs[i].d;
      step();
      check("q_d4", i, {3'b0, q4}, {3'b0, vecs[i].exp_q});
      check("q_d1", i, {3'b0, q1}, vecs[i].rst ? 4'h0 : {3'b0, vecs[i].d});
    end

    // DEPTH=8/WIDTH=4: reset value, then word 5 exits after 8 edges.
    reset = 1'b1;
    d8    = 4'hF;
    step();
    check("d8_reset", 0, q8, 4'hA);
    step();
    check("d8_reset", 1, q8, 4'hA);
    reset = 1'b0;
    d8    = 4'h5;
    for (int e = 1; e <= 9; e++) begin
      step();
      d8   = 4'h0;
      exp8 = (e < 8) ? 4'hA : (e == 8) ? 4'h5 : 4'h0;
      check("d8_word", e, q8, exp8);
    end

    // Random soak on DEPTH=4 with occasional reset against a reference chain.
    reset = 1'b1;
    d4    = 1'b0;
    step();
    for (int k = 0; k < 4; k++) model[k] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      rnd_rst = ($urandom_range(0, 31) == 0);
      rnd_d   = 1'($urandom_range(0, 1));
      reset   = rnd_rst;
      d4      = rnd_d;
      step();
      if (rnd_rst) begin
        for (int k = 0; k < 4; k++) model[k] = 1'b0;
      end else begin
        for (int k = 3; k > 0; k--) model[k] = model[k-1];
        model[0] = rnd_d;
      end
      check("soak", c, {3'b0, q4}, {3'b0, model[3]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
